// File: rtl/uart_pkg.sv
// Shared definitions for the streaming UART transmitter: FSM encodings, parity modes
// and the width of the per-frame configuration bundle.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  // data + length field + parity mode + stop2 + msb_first
  function automatic int unsigned cfg_width(input int unsigned max_data_w);
    return max_data_w + $clog2(max_data_w) + 4;
  endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// Frame request channel: valid/ready handshake carrying data and per-frame configuration.
interface uart_tx_stream_if #(
  parameter int unsigned MAX_DATA_W = 9
);
  localparam int unsigned LEN_W = $clog2(MAX_DATA_W);

  logic                  tx_valid;
  logic                  tx_ready;
  logic [MAX_DATA_W-1:0] tx_data;
  logic [LEN_W-1:0]      tx_len;
  logic [1:0]            tx_par;
  logic                  tx_stop2;
  logic                  tx_msb_first;

  modport master (
    output tx_valid, tx_data, tx_len, tx_par, tx_stop2, tx_msb_first,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, tx_data, tx_len, tx_par, tx_stop2, tx_msb_first,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_hold.sv
// One-entry holding register for frame requests. Clamps the length and zeroes data bits
// above it at capture, so downstream parity can simply reduce the whole word.
module uart_tx_hold
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_W = 9,
  localparam int unsigned LEN_W = $clog2(MAX_DATA_W)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tx_en,
  input  logic                  unload,
  uart_tx_stream_if.slave       tx,
  output logic                  full,
  output logic                  load,
  output logic [MAX_DATA_W-1:0] data,
  output logic [LEN_W-1:0]      len,
  output logic [1:0]            par,
  output logic                  stop2,
  output logic                  msb_first
);

  localparam int unsigned        CFG_W   = cfg_width(MAX_DATA_W);
  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_DATA_W - 1);

  logic [CFG_W-1:0]      cfg_q;
  logic                  full_q;
  logic [LEN_W-1:0]      len_c;
  logic [MAX_DATA_W-1:0] data_c;

  // Reset gates ready so nothing is accepted while the block is held in reset.
  assign tx.tx_ready = rst_ni & tx_en & ~full_q;
  assign load        = tx.tx_valid & tx.tx_ready;

  always_comb begin
    len_c  = (tx.tx_len > LEN_MAX) ? LEN_MAX : tx.tx_len;
    data_c = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      data_c[i] = (i <= int'(len_c)) ? tx.tx_data[i] : 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      cfg_q  <= '0;
    end else if (load) begin
      full_q <= 1'b1;
      cfg_q  <= {tx.tx_msb_first, tx.tx_stop2, tx.tx_par, len_c, data_c};
    end else if (unload) begin
      full_q <= 1'b0;
    end
  end

  assign full = full_q;
  assign {msb_first, stop2, par, len, data} = cfg_q;

endmodule

// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: frame FSM, oversample/bit counters and parity, fed by a
// one-entry holding register so consecutive frames leave with no idle gap.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_W = 9,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            baud_en_i,
  input  logic            tx_en_i,
  input  logic            break_i,
  uart_tx_stream_if.slave tx,
  output logic            tx_busy_o,
  output logic            tx_done_o,
  output logic            uart_tx_o
);

  localparam int unsigned    OS_W    = $clog2(OVERSAMPLE);
  localparam int unsigned    LEN_W   = $clog2(MAX_DATA_W);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic                  hold_full, hold_load, unload;
  logic [MAX_DATA_W-1:0] hold_data;
  logic [LEN_W-1:0]      hold_len;
  logic [1:0]            hold_par;
  logic                  hold_stop2, hold_msb;

  uart_tx_hold #(
    .MAX_DATA_W(MAX_DATA_W)
  ) u_hold (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .tx_en    (tx_en_i),
    .unload   (unload),
    .tx       (tx),
    .full     (hold_full),
    .load     (hold_load),
    .data     (hold_data),
    .len      (hold_len),
    .par      (hold_par),
    .stop2    (hold_stop2),
    .msb_first(hold_msb)
  );

  logic [2:0]            state_q, state_d;
  logic [OS_W-1:0]       os_q, os_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic                  stop_q, stop_d;
  logic                  brk_q, brk_d;
  logic [MAX_DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [1:0]            par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  msb_q, msb_d;
  logic                  done_d, done_q;
  logic                  line_c, line_q, busy_q;
  logic                  bit_end, idle_next;
  logic [LEN_W-1:0]      sel;

  assign bit_end = (os_q == OS_LAST);

  always_comb begin
    state_d   = state_q;
    os_d      = os_q;
    idx_d     = idx_q;
    stop_d    = stop_q;
    brk_d     = brk_q;
    data_d    = data_q;
    len_d     = len_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    msb_d     = msb_q;
    done_d    = 1'b0;
    unload    = 1'b0;
    idle_next = 1'b0;
    if (baud_en_i) begin
      os_d = bit_end ? '0 : os_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          os_d      = '0;
          idle_next = 1'b1;
        end
        ST_START: if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
        ST_DATA: if (bit_end) begin
          if (idx_q == len_q) state_d = (par_q != PAR_NONE) ? ST_PARITY : ST_STOP;
          else                idx_d   = idx_q + 1'b1;
        end
        ST_PARITY: if (bit_end) state_d = ST_STOP;
        ST_STOP: if (bit_end) begin
          if (stop2_q && !stop_q && !brk_q) begin
            stop_d = 1'b1;
          end else begin
            stop_d = 1'b0;
            if (brk_q) begin
              brk_d   = 1'b0;
              state_d = ST_IDLE;
            end else begin
              done_d    = 1'b1;
              idle_next = 1'b1;
            end
          end
        end
        ST_BREAK: if (bit_end && !break_i) begin
          state_d = ST_STOP;
          brk_d   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
      // Shared by IDLE and the last stop tick so a pending frame starts with no gap.
      if (idle_next) begin
        if (break_i) begin
          state_d = ST_BREAK;
        end else if (hold_full && tx_en_i) begin
          state_d = ST_START;
          unload  = 1'b1;
          data_d  = hold_data;
          len_d   = hold_len;
          par_d   = hold_par;
          stop2_d = hold_stop2;
          msb_d   = hold_msb;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  assign sel = msb_q ? (len_q - idx_q) : idx_q;

  always_comb begin
    case (state_q)
      ST_START:  line_c = 1'b0;
      ST_DATA:   line_c = data_q[sel];
      ST_PARITY: begin
        case (par_q)
          PAR_EVEN: line_c = ^data_q;
          PAR_ODD:  line_c = ~^data_q;
          default:  line_c = 1'b1;
        endcase
      end
      ST_BREAK:  line_c = 1'b0;
      default:   line_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      os_q    <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      brk_q   <= 1'b0;
      data_q  <= '0;
      len_q   <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      msb_q   <= 1'b0;
      done_q  <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      brk_q   <= brk_d;
      data_q  <= data_d;
      len_q   <= len_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      msb_q   <= msb_d;
      done_q  <= done_d;
      line_q  <= line_c;
      busy_q  <= (state_q != ST_IDLE);
    end
  end

  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;
  assign uart_tx_o = line_q;

endmodule
